// File: rtl/seq_add_multiplier.sv
// Unsigned multiply by repeated addition; done pulses n+1 cycles after the accept edge (n = b, or min(a,b) with MUL_SWAP_EN).
// No backpressure: start is honoured only while idle, and is dropped (never queued) while busy.
module seq_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   ld_a;
   logic [WIDTH-1:0]   ld_cnt;

`ifdef MUL_SWAP_EN
   // Iterate over the smaller operand; equal operands take the no-swap path.
   always_comb begin
      ld_a   = a;
      ld_cnt = b;
      if (a < b) begin
         ld_a   = b;
         ld_cnt = a;
      end
   end
`else
   always_comb begin
      ld_a   = a;
      ld_cnt = b;
   end
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_a    <= '0;
         cnt     <= '0;
         acc     <= '0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= ld_a;
                  cnt   <= ld_cnt;
                  acc   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  acc <= acc + {{WIDTH{1'b0}}, op_a};
                  cnt <= cnt - 1'b1;
               end else begin
                  // Only the finished sum ever reaches the port.
                  product <= acc;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_add_multiplier.sv
// Directed bench for seq_add_multiplier (WIDTH=8); honours MUL_SWAP_EN for latency expectations.
module tb_seq_add_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int tests;
   int failed;

   seq_add_multiplier #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int iters(input logic [7:0] ta, input logic [7:0] tb_);
`ifdef MUL_SWAP_EN
      return (ta < tb_) ? int'(ta) : int'(tb_);
`else
      return int'(tb_);
`endif
   endfunction

   // One full operation: accept, wait for done with a bound, check latency/result/idle return.
   // poke pulses start mid-RUN and again during the DONE cycle; both must be ignored.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [15:0] exp, input bit poke);
      int          n;
      int          cyc;
      logic [15:0] prev;
      bit          leak;
      n    = iters(ta, tb_);
      prev = product;
      a = ta; b = tb_; start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      check({tag, "_busy_accept"}, 32'(busy), 32'd1);
      cyc  = 0;
      leak = 1'b0;
      while (done !== 1'b1 && cyc < 300) begin
         if (product !== prev) leak = 1'b1;
         if (poke && cyc == 2) begin start = 1'b1; a = 8'd9; b = 8'd9; end
         if (poke && cyc == 3) start = 1'b0;
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
      check({tag, "_product"}, 32'(product), 32'(exp));
      check({tag, "_no_partial"}, 32'(leak), 32'd0);
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      if (poke) begin start = 1'b1; a = 8'd1; b = 8'd1; end
      tick();
      start = 1'b0;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, 32'(product), 32'(exp));
   endtask

   initial begin
      bit saw_done;
      tests  = 0;
      failed = 0;
      rst = 1'b1; start = 1'b1; a = 8'd3; b = 8'd4;

      // Reset held two edges with start asserted.
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      rst = 1'b0; start = 1'b0;
      tick();
      check("post_rst_idle", 32'(busy), 32'd0);

      run_op("m5x3", 8'd5, 8'd3, 16'd15, 1'b0);
      run_op("m200x0", 8'd200, 8'd0, 16'd0, 1'b0);
      run_op("m0x7", 8'd0, 8'd7, 16'd0, 1'b0);
      run_op("m255x255", 8'd255, 8'd255, 16'hFE01, 1'b0);
      run_op("m2x200", 8'd2, 8'd200, 16'd400, 1'b0);
      run_op("m10x20_poke", 8'd10, 8'd20, 16'd200, 1'b1);

      // Reset mid-RUN abandons the operation without a done pulse.
      a = 8'd50; b = 8'd100; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("midrun_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_rst_busy", 32'(busy), 32'd0);
      check("midrun_rst_product", 32'(product), 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
         tick();
      end
      check("midrun_rst_quiet", 32'(saw_done), 32'd0);

      run_op("m6x7", 8'd6, 8'd7, 16'd42, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
